// File: rtl/cpu_sequencer_pkg.sv
// Datapath select codes and opcode values shared by the PDP-8 sequencer and its datapath.
package cpu_sequencer_pkg;

   localparam int unsigned AC_W   = 3;
   localparam int unsigned PC_W   = 3;
   localparam int unsigned SKIP_W = 2;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 3;
   localparam int unsigned IOT_W  = 1;
   localparam int unsigned IR_W   = 1;
   localparam int unsigned MA_W   = 2;
   localparam int unsigned MD_W   = 1;

   localparam logic [AC_W-1:0] AC_NONE   = 3'd0;
   localparam logic [AC_W-1:0] AC_AND_MD = 3'd1;
   localparam logic [AC_W-1:0] AC_ADD_MD = 3'd2;
   localparam logic [AC_W-1:0] AC_CLEAR  = 3'd3;
   localparam logic [AC_W-1:0] AC_OPR    = 3'd4;

   localparam logic [PC_W-1:0] PC_NONE = 3'd0;
   localparam logic [PC_W-1:0] PC_INCR = 3'd1;
   localparam logic [PC_W-1:0] PC_MA   = 3'd2;
   localparam logic [PC_W-1:0] PC_MA1  = 3'd3;
   localparam logic [PC_W-1:0] PC_ONE  = 3'd4;

   localparam logic [SKIP_W-1:0] SKIP_NONE     = 2'd0;
   localparam logic [SKIP_W-1:0] SKIP_MD_CLEAR = 2'd1;
   localparam logic [SKIP_W-1:0] SKIP_OPR      = 2'd2;
   localparam logic [SKIP_W-1:0] SKIP_IOT      = 2'd3;

   localparam logic [ADDR_W-1:0] ADDR_NONE = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_PC   = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_EA   = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_MA   = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = 3'd4;

   localparam logic [DATA_W-1:0] DATA_NONE = 3'd0;
   localparam logic [DATA_W-1:0] DATA_AC   = 3'd1;
   localparam logic [DATA_W-1:0] DATA_PC   = 3'd2;
   localparam logic [DATA_W-1:0] DATA_PC1  = 3'd3;
   localparam logic [DATA_W-1:0] DATA_MA   = 3'd4;
   localparam logic [DATA_W-1:0] DATA_MD1  = 3'd5;

   localparam logic [IOT_W-1:0] IOT_NONE  = 1'd0;
   localparam logic [IOT_W-1:0] IOT_PULSE = 1'd1;

   localparam logic [IR_W-1:0] IR_NONE = 1'd0;
   localparam logic [IR_W-1:0] IR_DATA = 1'd1;

   localparam logic [MA_W-1:0] MA_NONE  = 2'd0;
   localparam logic [MA_W-1:0] MA_EA    = 2'd1;
   localparam logic [MA_W-1:0] MA_DATA  = 2'd2;
   localparam logic [MA_W-1:0] MA_DATA1 = 2'd3;

   localparam logic [MD_W-1:0] MD_NONE = 1'd0;
   localparam logic [MD_W-1:0] MD_DATA = 1'd1;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_TAD = 3'd1;
   localparam logic [2:0] OP_ISZ = 3'd2;
   localparam logic [2:0] OP_DCA = 3'd3;
   localparam logic [2:0] OP_JMS = 3'd4;
   localparam logic [2:0] OP_JMP = 3'd5;
   localparam logic [2:0] OP_IOT = 3'd6;
   localparam logic [2:0] OP_OPR = 3'd7;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath/memory bundle: instruction fields and handshake in, selects and strobes out.
interface cpu_sequencer_if;
   import cpu_sequencer_pkg::*;

   logic              run;
   logic              step;
   logic [2:0]        opcode;
   logic              indirect;
   logic              ea_auto;
   logic              int_req;
   logic              ion;
   logic              mem_valid;

   logic [AC_W-1:0]   sel_ac;
   logic [PC_W-1:0]   sel_pc;
   logic [SKIP_W-1:0] sel_skip;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [IOT_W-1:0]  sel_iot;
   logic [IR_W-1:0]   sel_ir;
   logic [MA_W-1:0]   sel_ma;
   logic [MD_W-1:0]   sel_md;
   logic              mem_read;
   logic              mem_write;
   logic              halted;
   logic              fault;
   logic              int_ack;
   logic [3:0]        state_o;

   modport master (
      input  run, step, opcode, indirect, ea_auto, int_req, ion, mem_valid,
      output sel_ac, sel_pc, sel_skip, sel_addr, sel_data, sel_iot, sel_ir, sel_ma, sel_md,
      output mem_read, mem_write, halted, fault, int_ack, state_o
   );

   modport slave (
      output run, step, opcode, indirect, ea_auto, int_req, ion, mem_valid,
      input  sel_ac, sel_pc, sel_skip, sel_addr, sel_data, sel_iot, sel_ir, sel_ma, sel_md,
      input  mem_read, mem_write, halted, fault, int_ack, state_o
   );

endinterface

// File: rtl/cpu_sequencer.sv
// PDP-8 style major-state sequencer: walks fetch/defer/execute/interrupt states and
// drives combinational datapath selects and memory strobes, with a memory-wait watchdog.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned AUTOINDEX   = 1,
   parameter int unsigned INTERRUPTS  = 1
) (
   input logic            clk,
   input logic            reset,
   cpu_sequencer_if.master bus
);

   localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam int unsigned TW = CW + 1;

   typedef enum logic [3:0] {
      S_HALT    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_IND     = 4'd3,
      S_AUTOINC = 4'd4,
      S_EXEC    = 4'd5,
      S_EXEC2   = 4'd6,
      S_INT     = 4'd7,
      S_FAULT   = 4'd8
   } state_e;

   state_e        state;
   state_e        state_next;
   logic [CW-1:0] wait_cnt;
   logic [TW-1:0] wait_inc;
   logic          rd;
   logic          wr;
   logic          done;

   assign wait_inc      = {1'b0, wait_cnt} + TW'(1);
   assign bus.mem_read  = rd;
   assign bus.mem_write = wr;
   assign bus.state_o   = state;

   // Wait counter saturates so a zero count only ever means "first cycle in this state".
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_HALT;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if (state_next != state) begin
            wait_cnt <= '0;
         end else if ((rd || wr) && !bus.mem_valid && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      state_next   = state;
      rd           = 1'b0;
      wr           = 1'b0;
      done         = 1'b0;
      bus.sel_ac   = AC_NONE;
      bus.sel_pc   = PC_NONE;
      bus.sel_skip = SKIP_NONE;
      bus.sel_addr = ADDR_NONE;
      bus.sel_data = DATA_NONE;
      bus.sel_iot  = IOT_NONE;
      bus.sel_ir   = IR_NONE;
      bus.sel_ma   = MA_NONE;
      bus.sel_md   = MD_NONE;
      bus.halted   = 1'b0;
      bus.fault    = 1'b0;
      bus.int_ack  = 1'b0;

      case (state)
         S_HALT: begin
            bus.halted = 1'b1;
            if (bus.run) state_next = S_FETCH;
         end
         S_FETCH: begin
            if (INTERRUPTS != 0 && wait_cnt == '0 && bus.int_req && bus.ion) begin
               state_next = S_INT;
            end else begin
               rd           = 1'b1;
               bus.sel_addr = ADDR_PC;
               bus.sel_ir   = IR_DATA;
               if (bus.mem_valid) state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (bus.opcode == OP_IOT || bus.opcode == OP_OPR) begin
               state_next = S_EXEC;
            end else if (bus.indirect) begin
               state_next = S_IND;
            end else begin
               bus.sel_ma = MA_EA;
               state_next = S_EXEC;
            end
         end
         S_IND: begin
            rd           = 1'b1;
            bus.sel_addr = ADDR_EA;
            bus.sel_ma   = MA_DATA;
            if (bus.mem_valid) state_next = (AUTOINDEX != 0 && bus.ea_auto) ? S_AUTOINC : S_EXEC;
         end
         S_AUTOINC: begin
            wr           = 1'b1;
            bus.sel_addr = ADDR_EA;
            bus.sel_data = DATA_MA;
            bus.sel_ma   = MA_DATA1;
            if (bus.mem_valid) state_next = S_EXEC;
         end
         S_EXEC: begin
            case (bus.opcode)
               OP_AND, OP_TAD, OP_ISZ: begin
                  rd           = 1'b1;
                  bus.sel_addr = ADDR_MA;
                  bus.sel_md   = MD_DATA;
                  if (bus.mem_valid) state_next = S_EXEC2;
               end
               OP_DCA: begin
                  wr           = 1'b1;
                  bus.sel_addr = ADDR_MA;
                  bus.sel_data = DATA_AC;
                  if (bus.mem_valid) begin
                     bus.sel_ac = AC_CLEAR;
                     bus.sel_pc = PC_INCR;
                     done       = 1'b1;
                  end
               end
               OP_JMS: begin
                  wr           = 1'b1;
                  bus.sel_addr = ADDR_MA;
                  bus.sel_data = DATA_PC1;
                  if (bus.mem_valid) begin
                     bus.sel_pc = PC_MA1;
                     done       = 1'b1;
                  end
               end
               OP_JMP: begin
                  bus.sel_pc = PC_MA;
                  done       = 1'b1;
               end
               OP_IOT: begin
                  bus.sel_iot  = IOT_PULSE;
                  bus.sel_skip = SKIP_IOT;
                  bus.sel_pc   = PC_INCR;
                  done         = 1'b1;
               end
               default: begin
                  bus.sel_ac   = AC_OPR;
                  bus.sel_skip = SKIP_OPR;
                  bus.sel_pc   = PC_INCR;
                  done         = 1'b1;
               end
            endcase
         end
         S_EXEC2: begin
            case (bus.opcode)
               OP_AND: begin
                  bus.sel_ac = AC_AND_MD;
                  bus.sel_pc = PC_INCR;
                  done       = 1'b1;
               end
               OP_TAD: begin
                  bus.sel_ac = AC_ADD_MD;
                  bus.sel_pc = PC_INCR;
                  done       = 1'b1;
               end
               OP_ISZ: begin
                  wr           = 1'b1;
                  bus.sel_addr = ADDR_MA;
                  bus.sel_data = DATA_MD1;
                  if (bus.mem_valid) begin
                     bus.sel_skip = SKIP_MD_CLEAR;
                     bus.sel_pc   = PC_INCR;
                     done         = 1'b1;
                  end
               end
               default: done = 1'b1;
            endcase
         end
         S_INT: begin
            bus.int_ack  = (INTERRUPTS != 0) && (wait_cnt == '0);
            wr           = 1'b1;
            bus.sel_addr = ADDR_ZERO;
            bus.sel_data = DATA_PC;
            if (bus.mem_valid) begin
               bus.sel_pc = PC_ONE;
               state_next = S_FETCH;
            end
         end
         S_FAULT: begin
            bus.fault  = 1'b1;
            bus.halted = 1'b1;
         end
         default: state_next = S_HALT;
      endcase

      if (done) state_next = bus.step ? S_HALT : S_FETCH;

      // A valid handshake on the last allowed wait cycle wins over the timeout.
      if (MEM_TIMEOUT != 0 && (rd || wr) && !bus.mem_valid && wait_inc == TW'(MEM_TIMEOUT)) begin
         state_next = S_FAULT;
      end
   end

endmodule
